// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter:
// FSM encoding, port identifiers, wait-counter width and the latched access record.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  localparam int   CNT_W    = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: CPU and debug requester ports plus the single-port memory side.
// slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;

  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_ready;
  logic        dbg_err;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_err,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ready, dbg_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_err,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ready, dbg_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin grant: on contention the port not granted last wins.
// The last-grant flag updates whenever en is high and some request is present.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       valid,
  output logic       grant
);

  logic last_reg;

  assign valid = |req;

  always_comb begin
    grant = PORT_CPU;
    if (req == 2'b11) begin
      grant = ~last_reg;
    end else if (req[PORT_DBG]) begin
      grant = PORT_DBG;
    end
  end

  // Starting as "debug granted last" lets the CPU win the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= PORT_DBG;
    end else if (en && valid) begin
      last_reg <= grant;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto one single-port memory with fixed read latency.
// Optional alignment check: define MEM_ARBITER_ALIGN_CHK_EN to reject addr[1:0]!=0 with an error pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
)
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  acc_t             acc_reg;
  logic             gnt_reg;

  acc_t             sel_acc;
  logic [1:0]       req_vec;
  logic             arb_en;
  logic             arb_valid;
  logic             arb_grant;
  logic             load;
  logic             capture;

  logic [1:0]       ready_vec;
  logic [1:0]       err_vec;
  logic [1:0][31:0] rdata_vec;

  assign req_vec[PORT_CPU] = bus.cpu_req;
  assign req_vec[PORT_DBG] = bus.dbg_req;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .req   (req_vec),
    .en    (arb_en),
    .valid (arb_valid),
    .grant (arb_grant)
  );

  always_comb begin
    sel_acc = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
    if (arb_grant == PORT_DBG) begin
      sel_acc = '{we: bus.dbg_we, addr: bus.dbg_addr, wdata: bus.dbg_wdata};
    end
  end

`ifdef MEM_ARBITER_ALIGN_CHK_EN
  logic sel_bad;
  logic err_reg;

  assign sel_bad = misaligned(sel_acc.addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (load) begin
      err_reg <= sel_bad;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    arb_en     = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        arb_en = 1'b1;
        if (arb_valid) begin
          load       = 1'b1;
          state_next = ST_ACCESS;
`ifdef MEM_ARBITER_ALIGN_CHK_EN
          if (sel_bad) begin
            state_next = ST_DONE;
          end
`endif
        end
      end
      ST_ACCESS: begin
        cnt_next   = CNT_W'(WAIT_CYCLES);
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        // Memory data is valid in the WAIT cycle whose count is 1.
        if (cnt_reg <= CNT_W'(1)) begin
          capture    = ~acc_reg.we;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      gnt_reg   <= PORT_CPU;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (load) begin
        acc_reg <= sel_acc;
        gnt_reg <= arb_grant;
      end
    end
  end

  assign bus.mem_en    = (state_reg == ST_ACCESS);
  assign bus.mem_we    = (state_reg == ST_ACCESS) && acc_reg.we;
  assign bus.mem_addr  = acc_reg.addr;
  assign bus.mem_wdata = acc_reg.wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [31:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg <= '0;
        end else if (capture && (gnt_reg == 1'(gi))) begin
          rdata_reg <= bus.mem_rdata;
        end
      end

      assign rdata_vec[gi] = rdata_reg;
      assign ready_vec[gi] = (state_reg == ST_DONE) && (gnt_reg == 1'(gi));
`ifdef MEM_ARBITER_ALIGN_CHK_EN
      assign err_vec[gi]   = ready_vec[gi] && err_reg;
`else
      assign err_vec[gi]   = 1'b0;
`endif
    end
  endgenerate

  assign bus.cpu_rdata = rdata_vec[PORT_CPU];
  assign bus.cpu_ready = ready_vec[PORT_CPU];
  assign bus.cpu_err   = err_vec[PORT_CPU];
  assign bus.dbg_rdata = rdata_vec[PORT_DBG];
  assign bus.dbg_ready = ready_vec[PORT_DBG];
  assign bus.dbg_err   = err_vec[PORT_DBG];

endmodule
